rr_arb_16: RTL and testbench
============================

Name: rr_arb_16

Overview:
16-requester round-robin arbiter with a grant-hold handshake and a watchdog.
- Keeps the last-granted index, builds a thermometer priority mask from it, and picks the next requester above that index, wrapping to index 0.
- Sits between the request aggregators and the shared-resource port it controls.
- Holds each grant until the owner acks, drops its request, or the watchdog expires.

Parameters:
- TIMEOUT, 255: cycles a grant may be held without ack before forced release; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  16  request vector, bit i = requester i.
- ack  in  1  owner done; releases the current grant.
- grant  out  16  one-hot grant, all zero when idle.
- grant_idx  out  4  binary index of the current or most recent grant.
- grant_vld  out  1  high while grant is non-zero.
- timeout  out  1  one-cycle pulse on watchdog forced release.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - grant=0, grant_idx=0, grant_vld=0, timeout=0.
  - Internal last_idx=15, so the first arbitration favours index 0.
  - State=IDLE, watchdog count=0.
  - Reset takes effect mid-grant too: the grant drops on the next edge, with no timeout pulse.
- Priority mask, combinational: above[i]=1 for all i > last_idx. At last_idx=15, above=0.
- Winner selection:
  - upper = req & above.
  - If upper is non-zero, the winner is the lowest set bit of upper.
  - Otherwise the winner is the lowest set bit of req.
- IDLE state:
  - If |req at an edge: register grant=onehot(winner), grant_idx=winner, grant_vld=1, count=0, go to GRANT.
  - Latency is 1 cycle from req to grant.
  - If req=0, stay in IDLE; outputs are unchanged apart from grant=0 and grant_vld=0.
- GRANT state. Release triggers are evaluated each edge, in this priority:
  1. ack=1: release.
  2. req[grant_idx]=0: release. A requester withdrawing counts as a release.
  3. TIMEOUT!=0 and count==TIMEOUT-1: release and set timeout=1 for that cycle.
  4. None of the above: count+1, grant held.
- On release:
  - grant=0, grant_vld=0, last_idx=grant_idx, go to IDLE.
  - grant_idx keeps its value.
  - There is always one idle cycle between grants. No back-to-back grants.
- Requests arriving during GRANT are not considered until IDLE. Changes to req bits other than grant_idx have no effect during GRANT.
- Simultaneous ack and timeout condition: ack wins, no timeout pulse.
- Fairness: a continuously requesting input is granted within 16 arbitration rounds.
- Counter arithmetic: unsigned, CNT_W bits, no wrap reachable given the parameter constraint.

Decomposition:
- Shared package:
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Constant N_REQ=16.
  - Constant IDX_W=4.
- One sub-module, prio_enc_16: combinational lowest-set-bit finder.
  - Ports: 16-bit vector in; 4-bit index and any-valid flag out.
  - Instantiated twice: once for upper, once for req.
- Mask generation and the state machine stay in rr_arb_16.

Test Plan:
1. Reset, then req=16'h0001 -> one cycle later grant=16'h0001, grant_idx=0, grant_vld=1. Then ack=1 -> next cycle grant=0, grant_vld=0.
2. req=16'hFFFF held, ack pulsed each time a grant appears -> grant_idx sequence is 0,1,2,...,15,0, with one idle cycle between grants.
3. last grant idx=5, then req=16'h0021 (bits 0 and 5) -> grant_idx=0 via wrap. Next, req=16'h0041 -> grant_idx=6.
4. TIMEOUT=4, req=16'h0100 held, no ack -> grant held 4 cycles, timeout=1 for exactly 1 cycle on release, then re-granted to 8 after the idle cycle.
5. Grant held on idx 3, req[3] drops while other bits stay set -> release next cycle, timeout=0, next winner is the lowest requester above 3.
6. rst_n=0 asserted during grant on idx 9 -> next cycle grant=0, grant_idx=0, timeout=0. With req=16'h0200 after reset, the grant goes to idx 9 (priority restarts from 0).

Source files
------------

// File: rtl/rr_arb_16_pkg.sv
// Shared types and constants for the 16-requester round-robin arbiter.
package rr_arb_16_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb_16_prio_enc.sv
// Lowest-set-bit finder over a 16-bit vector.
module prio_enc_16
  import rr_arb_16_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    // Scan high to low so the lowest set bit is written last and wins.
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (vec[i-1]) idx = IDX_W'(i - 1);
    end
    vld = |vec;
  end

endmodule

// File: rtl/rr_arb_16.sv
// Round-robin arbiter: one-hot grant held until ack, request drop or watchdog expiry.
module rr_arb_16
  import rr_arb_16_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             timeout
);

  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             grant_vld_q, grant_vld_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] above;
  logic [N_REQ-1:0] upper;
  logic [IDX_W-1:0] upper_idx, req_idx, winner;
  logic             upper_vld, req_vld;

  always_comb begin
    above = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      above[i] = (IDX_W'(i) > last_idx_q);
    end
  end

  assign upper = req & above;

  prio_enc_16 u_enc_upper (
    .vec (upper),
    .idx (upper_idx),
    .vld (upper_vld)
  );

  prio_enc_16 u_enc_req (
    .vec (req),
    .idx (req_idx),
    .vld (req_vld)
  );

  assign winner = upper_vld ? upper_idx : req_idx;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    grant_vld_d = grant_vld_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d     = '0;
        grant_vld_d = 1'b0;
        if (req_vld) begin
          grant_d     = N_REQ'(1) << winner;
          grant_idx_d = winner;
          grant_vld_d = 1'b1;
          cnt_d       = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Release priority: ack, then requester withdrawal, then watchdog.
        if (ack || !req[grant_idx_q] || (WD_EN && cnt_q == TO_LAST)) begin
          grant_d     = '0;
          grant_vld_d = 1'b0;
          last_idx_d  = grant_idx_q;
          state_d     = IDLE;
          timeout_d   = !ack && req[grant_idx_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_W'(N_REQ - 1);
      grant_vld_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      grant_vld_q <= grant_vld_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign grant_vld = grant_vld_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb_16.sv
// Self-checking bench for rr_arb_16: directed scenarios plus randomized traffic vs a reference model.
module tb_rr_arb_16;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        ack;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_vld;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_busy;
  int m_idx, m_last, m_cnt;
  bit m_to;

  always #5 clk = ~clk;

  rr_arb_16 #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Rotating search starting just after the last winner.
  function automatic int pick(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      if (r[(last + k) % 16]) return (last + k) % 16;
    end
    return 0;
  endfunction

  task automatic model_edge(input logic [15:0] r, input logic a, input logic rn);
    if (!rn) begin
      m_busy = 0; m_idx = 0; m_last = 15; m_cnt = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (r != 0) begin
          m_idx = pick(r, m_last); m_busy = 1; m_cnt = 0;
        end
      end else if (a || !r[m_idx]) begin
        m_busy = 0; m_last = m_idx;
      end else if (TB_TIMEOUT != 0 && m_cnt == TB_TIMEOUT - 1) begin
        m_busy = 0; m_last = m_idx; m_to = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [15:0] r, input logic a, input logic rn);
    req = r; ack = a; rst_n = rn;
    @(posedge clk);
    model_edge(r, a, rn);
    #1;
    check("grant",     32'(grant),     m_busy ? (32'd1 << m_idx) : 32'd0);
    check("grant_idx", 32'(grant_idx), 32'(m_idx));
    check("grant_vld", 32'(grant_vld), 32'(m_busy));
    check("timeout",   32'(timeout),   32'(m_to));
  endtask

  logic [15:0] r_cur;
  logic        a_cur, rn_cur;

  initial begin
    req = '0; ack = 1'b0; rst_n = 1'b0;
    m_busy = 0; m_idx = 0; m_last = 15; m_cnt = 0; m_to = 0;

    step(16'h0000, 0, 0);
    step(16'h0000, 0, 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_vld",   32'(grant_vld), 0);

    // Single requester, ack release
    step(16'h0001, 0, 1);
    check("t1_grant", 32'(grant), 32'h0001);
    check("t1_vld",   32'(grant_vld), 1);
    step(16'h0001, 1, 1);
    check("t1_rel_grant", 32'(grant), 0);

    // Full rotation under constant requests
    step(16'h0000, 0, 0);
    for (int k = 0; k < 17; k++) begin
      step(16'hFFFF, 0, 1);
      check("t2_idx", 32'(grant_idx), 32'(k % 16));
      step(16'hFFFF, 1, 1);
      check("t2_idle", 32'(grant_vld), 0);
    end

    // Wrap-around
    step(16'h0020, 0, 1);
    check("t3_idx5", 32'(grant_idx), 5);
    step(16'h0020, 1, 1);
    step(16'h0021, 0, 1);
    check("t3_wrap", 32'(grant_idx), 0);
    step(16'h0021, 1, 1);
    step(16'h0041, 0, 1);
    check("t3_idx6", 32'(grant_idx), 6);
    step(16'h0041, 1, 1);

    // Requester withdraws
    step(16'h0008, 0, 1);
    check("t5_idx3", 32'(grant_idx), 3);
    step(16'h0030, 0, 1);
    check("t5_rel", 32'(grant_vld), 0);
    check("t5_noto", 32'(timeout), 0);
    step(16'h0031, 0, 1);
    check("t5_next", 32'(grant_idx), 4);
    step(16'h0000, 1, 1);

    // Watchdog expiry
    step(16'h0100, 0, 1);
    check("t4_idx8", 32'(grant_idx), 8);
    for (int k = 0; k < 3; k++) begin
      step(16'h0100, 0, 1);
      check("t4_held", 32'(grant_vld), 1);
    end
    step(16'h0100, 0, 1);
    check("t4_to", 32'(timeout), 1);
    check("t4_rel", 32'(grant_vld), 0);
    step(16'h0100, 0, 1);
    check("t4_to_clr", 32'(timeout), 0);
    check("t4_regrant", 32'(grant_idx), 8);
    // ack coinciding with watchdog expiry suppresses the pulse
    for (int k = 0; k < 3; k++) step(16'h0100, 0, 1);
    step(16'h0100, 1, 1);
    check("t4_ack_wins", 32'(timeout), 0);
    step(16'h0000, 0, 1);

    // Reset mid-grant
    step(16'h0200, 0, 1);
    check("t6_idx9", 32'(grant_idx), 9);
    step(16'h0200, 0, 0);
    check("t6_rst_grant", 32'(grant), 0);
    check("t6_rst_idx", 32'(grant_idx), 0);
    check("t6_rst_to", 32'(timeout), 0);
    step(16'h0200, 0, 1);
    check("t6_idx9b", 32'(grant_idx), 9);

    // Randomized traffic
    r_cur = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       r_cur = 16'h0000;
        1:       r_cur = 16'($urandom);
        2, 3:    r_cur = r_cur ^ (16'd1 << $urandom_range(0, 15));
        default: ;
      endcase
      a_cur  = ($urandom_range(0, 5) == 0);
      rn_cur = ($urandom_range(0, 199) != 0);
      step(r_cur, a_cur, rn_cur);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
